// File: rtl/q_result_collector_if.sv
// Result-collector handshake bundle: operand-issue credit, datapath return beat and
// downstream valid/ready result stream.
// slave  : collector side (consumes issue/q beats, produces results).
// master : environment side (operand source, datapath and downstream sink).
interface q_result_collector_if #(
  parameter int unsigned DATA_WIDTH = 16
) ();
  logic                         issue;
  logic                         issue_ready;
  logic signed [DATA_WIDTH-1:0] q;
  logic                         q_valid;
  logic signed [DATA_WIDTH-1:0] res;
  logic                         res_valid;
  logic                         res_ready;

  modport slave (
    input  issue, q, q_valid, res_ready,
    output issue_ready, res, res_valid
  );

  modport master (
    output issue, q, q_valid, res_ready,
    input  issue_ready, res, res_valid
  );
endinterface

// File: rtl/q_result_collector.sv
// Collects q beats from the back-pressure-free arithmetic datapath into a FIFO and
// hands them downstream over valid/ready. Issue credits guarantee a free slot for
// every launched operand set.
// Optional feature macro: Q_COLLECT_STATS_EN enables the 32-bit popped-result counter
// on res_cnt_o; otherwise res_cnt_o is tied to zero.
module q_result_collector #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                       clk_i,
  input  logic                       artsn_i,
  q_result_collector_if.slave        rc_io,
  output logic [$clog2(DEPTH+1)-1:0] level_o,
  output logic [$clog2(DEPTH+1)-1:0] inflight_o,
  output logic                       ovf_o,
  output logic                       err_o,
  output logic [31:0]                res_cnt_o
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);

  logic signed [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]              wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]              level_q, level_d;
  logic [CntW-1:0]              inflight_q, inflight_d;
  logic                         ovf_q, err_q;
  logic [CntW:0]                used;
  logic                         credit_ok, issue_ok, push, pop;

  // Credit and handshake decode; credit depends only on registers (and reset).
  always_comb begin
    used      = {1'b0, level_q} + {1'b0, inflight_q};
    credit_ok = artsn_i && (used < {1'b0, DepthC});
    issue_ok  = rc_io.issue && credit_ok;
    pop       = (level_q != '0) && rc_io.res_ready;
    // A full FIFO can still take a beat when the head leaves in the same cycle.
    push      = rc_io.q_valid && ((level_q != DepthC) || pop);
  end

  // Next occupancy and in-flight count.
  always_comb begin
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + CntW'(1);
      2'b01:   level_d = level_q - CntW'(1);
      default: level_d = level_q;
    endcase
    inflight_d = inflight_q;
    if (issue_ok && !rc_io.q_valid) begin
      inflight_d = inflight_q + CntW'(1);
    end else if (!issue_ok && rc_io.q_valid && (inflight_q != '0)) begin
      // A stray beat with nothing in flight saturates at zero.
      inflight_d = inflight_q - CntW'(1);
    end
  end

  // Storage, pointers, counters and sticky error flags.
  always_ff @(posedge clk_i or negedge artsn_i) begin
    if (!artsn_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      inflight_q <= '0;
      ovf_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= rc_io.q;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      level_q    <= level_d;
      inflight_q <= inflight_d;
      if (rc_io.q_valid && !push) begin
        ovf_q <= 1'b1;
      end
      if (rc_io.issue && !credit_ok) begin
        err_q <= 1'b1;
      end
    end
  end

`ifdef Q_COLLECT_STATS_EN
  logic [31:0] res_cnt_q;

  // Popped-result counter; wraps naturally at 2^32.
  always_ff @(posedge clk_i or negedge artsn_i) begin
    if (!artsn_i) begin
      res_cnt_q <= '0;
    end else if (pop) begin
      res_cnt_q <= res_cnt_q + 32'd1;
    end
  end

  assign res_cnt_o = res_cnt_q;
`else
  assign res_cnt_o = '0;
`endif

  assign rc_io.issue_ready = credit_ok;
  assign rc_io.res         = mem_q[rd_ptr_q];
  assign rc_io.res_valid   = (level_q != '0);
  assign level_o           = level_q;
  assign inflight_o        = inflight_q;
  assign ovf_o             = ovf_q;
  assign err_o             = err_q;

endmodule

// File: tb/tb_q_result_collector.sv
// Directed bench for q_result_collector (DEPTH = 4, DATA_WIDTH = 16): a table of
// per-cycle inputs with expected post-edge outputs, plus hand-written reset sequences.
module tb_q_result_collector;

  logic        clk;
  logic        artsn;
  logic [2:0]  level, inflight;
  logic        ovf, err;
  logic [31:0] res_cnt;

  q_result_collector_if #(.DATA_WIDTH(16)) rc ();

  q_result_collector #(
    .DATA_WIDTH(16),
    .DEPTH     (4)
  ) dut (
    .clk_i     (clk),
    .artsn_i   (artsn),
    .rc_io     (rc),
    .level_o   (level),
    .inflight_o(inflight),
    .ovf_o     (ovf),
    .err_o     (err),
    .res_cnt_o (res_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic               iss;
    logic               qv;
    logic signed [15:0] q;
    logic               rr;
    logic               ir;
    logic               rv;
    logic signed [15:0] res;
    int                 lvl;
    int                 inf;
    logic               ovf;
    logic               err;
  } vec_t;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   pops   = 0;
  logic prev_rv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic add(input logic iss, input logic qv, input int q, input logic rr,
                     input logic ir, input logic rv, input int res, input int lvl,
                     input int inf, input logic o, input logic e);
    vec_t v;
    v.iss = iss; v.qv = qv; v.q = 16'(q); v.rr = rr;
    v.ir = ir; v.rv = rv; v.res = 16'(res); v.lvl = lvl; v.inf = inf;
    v.ovf = o; v.err = e;
    vecs.push_back(v);
  endtask

  function automatic logic [31:0] exp_cnt(input int n);
`ifdef Q_COLLECT_STATS_EN
    return 32'(n);
`else
    return 32'(0 * n);
`endif
  endfunction

  task automatic idle_inputs();
    rc.issue = 1'b0; rc.q_valid = 1'b0; rc.q = '0; rc.res_ready = 1'b0;
  endtask

  initial begin
    //  iss qv  q    rr   ir rv res lvl inf ovf err
    // Single set: issue, result -7 three cycles later, drained next cycle.
    add(1, 0, 0,   1,   1, 0, 0,  0, 1, 0, 0);
    add(0, 0, 0,   1,   1, 0, 0,  0, 1, 0, 0);
    add(0, 0, 0,   1,   1, 0, 0,  0, 1, 0, 0);
    add(0, 1, -7,  1,   1, 1, -7, 1, 0, 0, 0);
    add(0, 0, 0,   1,   1, 0, 0,  0, 0, 0, 0);
    // Four issues, stalled sink, returns 10..40, then drain.
    add(1, 0, 0,   0,   1, 0, 0,  0, 1, 0, 0);
    add(1, 0, 0,   0,   1, 0, 0,  0, 2, 0, 0);
    add(1, 0, 0,   0,   1, 0, 0,  0, 3, 0, 0);
    add(1, 1, 10,  0,   0, 1, 10, 1, 3, 0, 0);
    add(0, 1, 20,  0,   0, 1, 10, 2, 2, 0, 0);
    add(0, 1, 30,  0,   0, 1, 10, 3, 1, 0, 0);
    add(0, 1, 40,  0,   0, 1, 10, 4, 0, 0, 0);
    add(0, 0, 0,   1,   1, 1, 20, 3, 0, 0, 0);
    add(0, 0, 0,   1,   1, 1, 30, 2, 0, 0, 0);
    add(0, 0, 0,   1,   1, 1, 40, 1, 0, 0, 0);
    add(0, 0, 0,   1,   1, 0, 0,  0, 0, 0, 0);
    // Fill with stray beats, then push 50 while popping a full FIFO.
    add(0, 1, 1,   0,   1, 1, 1,  1, 0, 0, 0);
    add(0, 1, 2,   0,   1, 1, 1,  2, 0, 0, 0);
    add(0, 1, 3,   0,   1, 1, 1,  3, 0, 0, 0);
    add(0, 1, 4,   0,   0, 1, 1,  4, 0, 0, 0);
    add(0, 1, 50,  1,   0, 1, 2,  4, 0, 0, 0);
    add(0, 0, 0,   1,   1, 1, 3,  3, 0, 0, 0);
    add(0, 0, 0,   1,   1, 1, 4,  2, 0, 0, 0);
    add(0, 0, 0,   1,   1, 1, 50, 1, 0, 0, 0);
    add(0, 0, 0,   1,   1, 0, 0,  0, 0, 0, 0);
    // Overflow drop of 9, rejected issue, sticky flags, drain shows 9 absent.
    add(0, 1, 5,   0,   1, 1, 5,  1, 0, 0, 0);
    add(0, 1, 6,   0,   1, 1, 5,  2, 0, 0, 0);
    add(0, 1, 7,   0,   1, 1, 5,  3, 0, 0, 0);
    add(0, 1, 8,   0,   0, 1, 5,  4, 0, 0, 0);
    add(0, 1, 9,   0,   0, 1, 5,  4, 0, 1, 0);
    add(1, 0, 0,   0,   0, 1, 5,  4, 0, 1, 1);
    add(0, 0, 0,   0,   0, 1, 5,  4, 0, 1, 1);
    add(0, 0, 0,   1,   1, 1, 6,  3, 0, 1, 1);
    add(0, 0, 0,   1,   1, 1, 7,  2, 0, 1, 1);
    add(0, 0, 0,   1,   1, 1, 8,  1, 0, 1, 1);
    add(0, 0, 0,   1,   1, 0, 0,  0, 0, 1, 1);
    // Build level 2, inflight 1 ahead of the mid-transfer reset.
    add(0, 1, 11,  0,   1, 1, 11, 1, 0, 1, 1);
    add(0, 1, 12,  0,   1, 1, 11, 2, 0, 1, 1);
    add(1, 0, 0,   0,   1, 1, 11, 2, 1, 1, 1);

    idle_inputs();
    artsn = 1'b0;
    #12;
    chk("rst.ir",  32'(rc.issue_ready), 32'd0);
    chk("rst.rv",  32'(rc.res_valid),   32'd0);
    chk("rst.res", 32'($unsigned(rc.res)), 32'd0);
    @(negedge clk);
    artsn = 1'b1;
    @(posedge clk); #1;
    chk("idle.ir",  32'(rc.issue_ready), 32'd1);
    chk("idle.rv",  32'(rc.res_valid),   32'd0);
    chk("idle.lvl", 32'(level),          32'd0);
    chk("idle.inf", 32'(inflight),       32'd0);
    chk("idle.ovf", 32'(ovf),            32'd0);
    chk("idle.cnt", res_cnt,             32'd0);

    prev_rv = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rc.issue = vecs[i].iss; rc.q_valid = vecs[i].qv;
      rc.q = vecs[i].q;       rc.res_ready = vecs[i].rr;
      @(posedge clk); #1;
      if (vecs[i].rr && prev_rv) pops++;
      prev_rv = vecs[i].rv;
      chk($sformatf("v%0d.ir", i),  32'(rc.issue_ready), 32'(vecs[i].ir));
      chk($sformatf("v%0d.rv", i),  32'(rc.res_valid),   32'(vecs[i].rv));
      if (vecs[i].rv)
        chk($sformatf("v%0d.res", i), 32'($unsigned(rc.res)), 32'($unsigned(vecs[i].res)));
      chk($sformatf("v%0d.lvl", i), 32'(level),    32'(vecs[i].lvl));
      chk($sformatf("v%0d.inf", i), 32'(inflight), 32'(vecs[i].inf));
      chk($sformatf("v%0d.ovf", i), 32'(ovf),      32'(vecs[i].ovf));
      chk($sformatf("v%0d.err", i), 32'(err),      32'(vecs[i].err));
      chk($sformatf("v%0d.cnt", i), res_cnt,       exp_cnt(pops));
    end

    // Reset asserted between edges: outputs must clear without waiting for a clock.
    @(posedge clk); #3;
    idle_inputs();
    artsn = 1'b0;
    #1;
    chk("mid.ir",  32'(rc.issue_ready), 32'd0);
    chk("mid.rv",  32'(rc.res_valid),   32'd0);
    chk("mid.res", 32'($unsigned(rc.res)), 32'd0);
    chk("mid.lvl", 32'(level),    32'd0);
    chk("mid.inf", 32'(inflight), 32'd0);
    chk("mid.ovf", 32'(ovf),      32'd0);
    chk("mid.err", 32'(err),      32'd0);
    chk("mid.cnt", res_cnt,       32'd0);
    @(negedge clk);
    artsn = 1'b1;
    @(posedge clk); #1;
    chk("post.ir",  32'(rc.issue_ready), 32'd1);
    chk("post.lvl", 32'(level),          32'd0);

    // One push then one pop after reset; counter restarts from zero.
    @(negedge clk);
    rc.q_valid = 1'b1; rc.q = -16'sd3;
    @(posedge clk); #1;
    chk("post.rv1",  32'(rc.res_valid), 32'd1);
    chk("post.res",  32'($unsigned(rc.res)), 32'($unsigned(-16'sd3)));
    chk("post.cnt0", res_cnt, 32'd0);
    @(negedge clk);
    rc.q_valid = 1'b0; rc.res_ready = 1'b1;
    @(posedge clk); #1;
    chk("post.rv0",  32'(rc.res_valid), 32'd0);
    chk("post.cnt1", res_cnt, exp_cnt(1));
    @(negedge clk);
    idle_inputs();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
